// File: rtl/tone_envelope_pwm_pkg.sv
// Shared definitions for the tone envelope PWM voice: envelope states,
// amplitude width and the default timing/sustain parameters.
package tone_envelope_pwm_pkg;

    localparam int AMP_W = 8;

    localparam int             ENV_STEP_DIV_DEFAULT = 50000;
    localparam logic [AMP_W-1:0] SUSTAIN_LVL_DEFAULT = 8'd192;

    localparam logic [AMP_W-1:0] AMP_MAX  = '1;
    localparam logic [AMP_W-1:0] AMP_ZERO = '0;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

endpackage : tone_envelope_pwm_pkg

// File: rtl/pwm_dac8.sv
// 8-bit PWM DAC: free-running counter compared against the amplitude,
// with a registered output so the pin never sees a combinational path.
module pwm_dac8
    import tone_envelope_pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [AMP_W-1:0] amplitude,
    output logic             pwm_out
);

    logic [AMP_W-1:0] pwm_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_out <= (pwm_cnt < amplitude);
        end
    end

endmodule : pwm_dac8

// File: rtl/tone_envelope_pwm.sv
// ADSR-style envelope generator gating a square-wave tone into a 1-bit PWM
// speaker output. Envelope steps are paced by a free-running prescaler.
module tone_envelope_pwm
    import tone_envelope_pwm_pkg::*;
#(
    parameter int               ENV_STEP_DIV = ENV_STEP_DIV_DEFAULT,
    parameter logic [AMP_W-1:0] SUSTAIN_LVL  = SUSTAIN_LVL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    input  logic             key,
    output logic             pwm_out,
    output logic [AMP_W-1:0] env_level,
    output logic             busy
);

    localparam int                 PRESC_W    = (ENV_STEP_DIV > 1) ? $clog2(ENV_STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(ENV_STEP_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic               step_tick;

    env_state_t       state;
    env_state_t       state_nxt;
    logic [AMP_W-1:0] level_nxt;
    logic [AMP_W-1:0] amplitude;

    // Prescaler runs regardless of key or tone so envelope timing is fixed.
    assign step_tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (step_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        level_nxt = env_level;
        unique case (state)
            ENV_IDLE: begin
                if (key) state_nxt = ENV_ATTACK;
            end
            ENV_ATTACK: begin
                if (!key) begin
                    state_nxt = ENV_RELEASE;
                end else if (step_tick) begin
                    if (env_level != AMP_MAX) level_nxt = env_level + 1'b1;
                    if (level_nxt == AMP_MAX) state_nxt = ENV_DECAY;
                end
            end
            ENV_DECAY: begin
                if (!key) begin
                    state_nxt = ENV_RELEASE;
                end else if (step_tick) begin
                    // A sustain level at or above the current level exits without stepping.
                    if (env_level > SUSTAIN_LVL) level_nxt = env_level - 1'b1;
                    if (level_nxt <= SUSTAIN_LVL) state_nxt = ENV_SUSTAIN;
                end
            end
            ENV_SUSTAIN: begin
                if (!key) state_nxt = ENV_RELEASE;
            end
            ENV_RELEASE: begin
                if (key) begin
                    state_nxt = ENV_ATTACK;
                end else if (step_tick) begin
                    if (env_level != AMP_ZERO) level_nxt = env_level - 1'b1;
                    if (level_nxt == AMP_ZERO) state_nxt = ENV_IDLE;
                end
            end
            default: begin
                state_nxt = ENV_IDLE;
                level_nxt = AMP_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ENV_IDLE;
            env_level <= AMP_ZERO;
        end else begin
            state     <= state_nxt;
            env_level <= level_nxt;
        end
    end

    assign busy      = (state != ENV_IDLE);
    assign amplitude = tone_in ? env_level : AMP_ZERO;

    pwm_dac8 u_dac (
        .clk       (clk),
        .rst       (rst),
        .amplitude (amplitude),
        .pwm_out   (pwm_out)
    );

endmodule : tone_envelope_pwm

// File: tb/tb_tone_envelope_pwm.sv
// Self-checking bench for tone_envelope_pwm: constant vector table, corner
// sequences, and random key/tone traffic against a cycle-level reference model.
module tb_tone_envelope_pwm;

    localparam int DIV = 4;
    localparam int SUS = 250;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key = 1'b1;
    logic       tone_in = 1'b1;
    logic       pwm_out;
    logic [7:0] env_level;
    logic       busy;

    logic       key2 = 1'b0;
    logic       tone2 = 1'b0;
    logic       pwm2;
    logic [7:0] level2;
    logic       busy2;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b1;

    always #5 clk = ~clk;

    tone_envelope_pwm #(.ENV_STEP_DIV(DIV), .SUSTAIN_LVL(8'd250)) dut (
        .clk       (clk),
        .rst       (rst),
        .tone_in   (tone_in),
        .key       (key),
        .pwm_out   (pwm_out),
        .env_level (env_level),
        .busy      (busy)
    );

    // Second voice with a mid-scale sustain, used to hold amplitude 128.
    tone_envelope_pwm #(.ENV_STEP_DIV(DIV), .SUSTAIN_LVL(8'd128)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .tone_in   (tone2),
        .key       (key2),
        .pwm_out   (pwm2),
        .env_level (level2),
        .busy      (busy2)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    // Reference model: phases and level follow the envelope rules directly;
    // step ticks and the PWM ramp are derived from the cycle count since reset.
    typedef enum int {P_IDLE, P_ATTACK, P_DECAY, P_SUSTAIN, P_RELEASE} phase_t;
    phase_t m_phase = P_IDLE;
    int     m_level = 0;
    int     m_cyc   = 0;
    bit     m_pwm   = 1'b0;

    always @(posedge clk or negedge rst) begin
        phase_t ph;
        int     lvl;
        bit     tick;
        if (!rst) begin
            m_phase <= P_IDLE;
            m_level <= 0;
            m_cyc   <= 0;
            m_pwm   <= 1'b0;
        end else begin
            ph   = m_phase;
            lvl  = m_level;
            tick = (m_cyc % DIV) == DIV - 1;
            case (m_phase)
                P_IDLE:    if (key) ph = P_ATTACK;
                P_ATTACK:
                    if (!key) ph = P_RELEASE;
                    else if (tick) begin
                        lvl = (lvl + 1 > 255) ? 255 : lvl + 1;
                        if (lvl == 255) ph = P_DECAY;
                    end
                P_DECAY:
                    if (!key) ph = P_RELEASE;
                    else if (tick) begin
                        if (lvl > SUS) lvl = lvl - 1;
                        if (lvl <= SUS) ph = P_SUSTAIN;
                    end
                P_SUSTAIN: if (!key) ph = P_RELEASE;
                P_RELEASE:
                    if (key) ph = P_ATTACK;
                    else if (tick) begin
                        lvl = (lvl - 1 < 0) ? 0 : lvl - 1;
                        if (lvl == 0) ph = P_IDLE;
                    end
                default: ph = P_IDLE;
            endcase
            m_pwm   <= ((m_cyc % 256) < (tone_in ? m_level : 0));
            m_phase <= ph;
            m_level <= lvl;
            m_cyc   <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("model busy/pwm/level", {busy, pwm_out, env_level},
                  {(m_phase != P_IDLE), m_pwm, 8'(m_level)});
    end

    typedef struct {
        logic key;
        logic tone;
        int   cycles;
        int   exp_level;
        logic exp_busy;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic do_reset(input int n);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_level(input int lvl, input int budget, input string nm);
        int n = 0;
        while (env_level != 8'(lvl) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, env_level, lvl);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int n;

        // Cumulative edge counts since reset release: 1, 4, 1019, 1020, 1024,
        // 1039, 1040, 3043, 3044 (key drop lands on a tick), 3047, 3048, 4043, 4044, 4054.
        vecs[0]  = '{1'b1, 1'b1, 1,    0,   1'b1};
        vecs[1]  = '{1'b1, 1'b1, 3,    1,   1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1015, 254, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1,    255, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 4,    254, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 15,   251, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1,    250, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 2003, 250, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1,    250, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 3,    250, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1,    249, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 995,  1,   1'b1};
        vecs[12] = '{1'b0, 1'b1, 1,    0,   1'b0};
        vecs[13] = '{1'b0, 1'b0, 10,   0,   1'b0};

        // Reset held for 3 clocks with the key already pressed.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pwm_out", pwm_out, 0);
        check("reset env_level", env_level, 0);
        check("reset busy", busy, 0);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            key     = vecs[i].key;
            tone_in = vecs[i].tone;
            repeat (vecs[i].cycles) @(negedge clk);
            check($sformatf("vec%0d level", i), env_level, vecs[i].exp_level);
            check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
        end

        // Retrigger during release resumes from the current level.
        key = 1'b1;
        tone_in = 1'b1;
        wait_level(110, 1000, "attack to 110");
        key = 1'b0;
        wait_level(100, 200, "release to 100");
        key = 1'b1;
        @(negedge clk);
        check("retrigger level held", env_level, 100);
        check("retrigger busy", busy, 1);
        n = 0;
        while (env_level == 8'd100 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("retrigger next tick", env_level, 101);

        // PWM duty at a held amplitude of 128, then tone gated off.
        key  = 1'b1;
        key2 = 1'b1;
        tone2 = 1'b1;
        do_reset(2);
        repeat (1700) @(negedge clk);
        check("voice2 sustain level", level2, 128);
        check("voice2 busy", busy2, 1);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(pwm2);
        end
        check("pwm high count amp128", hi, 128);
        tone2 = 1'b0;
        repeat (2) @(negedge clk);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(pwm2);
        end
        check("pwm high count tone off", hi, 0);
        key2 = 1'b0;

        // Reset asserted mid-note aborts immediately, then waits for the key.
        key = 1'b1;
        tone_in = 1'b1;
        do_reset(2);
        wait_level(40, 400, "attack to 40");
        #2 rst = 1'b0;
        #1;
        check("midreset env_level", env_level, 0);
        check("midreset busy", busy, 0);
        check("midreset pwm_out", pwm_out, 0);
        key = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post reset idle busy", busy, 0);
        check("post reset idle level", env_level, 0);
        key = 1'b1;
        @(negedge clk);
        check("post reset key busy", busy, 1);

        // Random key/tone traffic checked cycle by cycle by the model.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) key = ~key;
            tone_in = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_tone_envelope_pwm
